// File: rtl/generateproof_deadlock_pkg.sv
// Shared types and helpers for the GenerateProof deadlock aggregator.
// Holds the FSM state encoding, the window counter width and the lowest-set-bit search.
package generateproof_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } dl_state_t;

  localparam int CNT_W = 16;

  // Index of the lowest set bit of v; 0 when v is all zeros.
  function automatic int unsigned lowest_set_idx(input logic [31:0] v);
    int unsigned r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/generateproof_deadlock_prienc.sv
// Lowest-set-bit priority encoder for the deadlock snapshot.
// Purely combinational; valid flags a non-zero input vector.
module generateproof_deadlock_prienc
  import generateproof_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic [NUM_MON-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [31:0] vec_ext;

  always_comb begin
    vec_ext                = '0;
    vec_ext[NUM_MON-1:0]   = vec;
    idx                    = IDX_W'(lowest_set_idx(vec_ext));
    valid                  = |vec;
  end

endmodule

// File: rtl/generateproof_hls_deadlock_aggregator.sv
// Persistence filter for monitor block flags: a non-zero pattern that holds for
// THRESH consecutive samples latches a sticky deadlock report until cleared.
module generateproof_hls_deadlock_aggregator
  import generateproof_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 1024,
  parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               deadlock_flag,
  output logic               deadlock_report,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic [NUM_MON-1:0] deadlock_vec,
  output logic [7:0]         deadlock_count
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);

  dl_state_t          state_reg, state_next;
  logic [NUM_MON-1:0] mon_q_reg;
  logic [NUM_MON-1:0] snap_reg, snap_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               enter_dl;

  logic               flag_reg;
  logic               report_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [NUM_MON-1:0] vec_reg;
  logic [7:0]         count_reg;

  logic [IDX_W-1:0]   prienc_idx;
  logic               prienc_valid;

  generateproof_deadlock_prienc #(
    .NUM_MON (NUM_MON),
    .IDX_W   (IDX_W)
  ) u_prienc (
    .vec   (snap_reg),
    .idx   (prienc_idx),
    .valid (prienc_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      mon_q_reg <= '0;
      snap_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mon_q_reg <= mon_block;
      snap_reg  <= snap_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    cnt_next   = cnt_reg;
    enter_dl   = 1'b0;
    if (clear) begin
      state_next = IDLE;
      snap_next  = '0;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (mon_q_reg != '0) begin
            state_next = SUSPECT;
            snap_next  = mon_q_reg;
            cnt_next   = CNT_W'(1);
          end else begin
            cnt_next = '0;
          end
        end
        SUSPECT: begin
          // A zero or a different pattern restarts the persistence window.
          if (mon_q_reg == '0) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (mon_q_reg != snap_reg) begin
            snap_next = mon_q_reg;
            cnt_next  = CNT_W'(1);
          end else if (cnt_reg == THRESH_M1) begin
            state_next = DEADLOCK;
            cnt_next   = THRESH_C;
            enter_dl   = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DEADLOCK: state_next = DEADLOCK;
        default: begin
          state_next = IDLE;
          snap_next  = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_reg   <= 1'b0;
      report_reg <= 1'b0;
      idx_reg    <= '0;
      vec_reg    <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      // The detection counter survives clear; only reset zeroes it.
      flag_reg   <= 1'b0;
      report_reg <= 1'b0;
      idx_reg    <= '0;
      vec_reg    <= '0;
    end else if (enter_dl) begin
      flag_reg   <= 1'b1;
      report_reg <= 1'b1;
      idx_reg    <= prienc_idx;
      vec_reg    <= snap_reg;
      if (count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
    end else begin
      report_reg <= 1'b0;
    end
  end

  assign deadlock_flag   = flag_reg;
  assign deadlock_report = report_reg;
  assign deadlock_idx    = idx_reg;
  assign deadlock_vec    = vec_reg;
  assign deadlock_count  = count_reg;

  // Outside IDLE the snapshot always holds a non-zero pattern.
  assert property (@(posedge clock) disable iff (!reset_n)
                   (state_reg != IDLE) |-> prienc_valid);

endmodule

// File: tb/tb_generateproof_hls_deadlock_aggregator.sv
// Directed bench for the deadlock aggregator with THRESH=8, NUM_MON=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_generateproof_hls_deadlock_aggregator;

  logic       clock;
  logic       reset_n;
  logic [3:0] mon_block;
  logic       clear;
  logic       deadlock_flag;
  logic       deadlock_report;
  logic [1:0] deadlock_idx;
  logic [3:0] deadlock_vec;
  logic [7:0] deadlock_count;

  int n_checks = 0;
  int n_pass   = 0;

  generateproof_hls_deadlock_aggregator #(
    .NUM_MON (4),
    .THRESH  (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mon_block       (mon_block),
    .clear           (clear),
    .deadlock_flag   (deadlock_flag),
    .deadlock_report (deadlock_report),
    .deadlock_idx    (deadlock_idx),
    .deadlock_vec    (deadlock_vec),
    .deadlock_count  (deadlock_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic f, input logic r,
                         input logic [1:0] i, input logic [3:0] v, input logic [7:0] c);
    check({tag, ".flag"},   32'(deadlock_flag),   32'(f));
    check({tag, ".report"}, 32'(deadlock_report), 32'(r));
    check({tag, ".idx"},    32'(deadlock_idx),    32'(i));
    check({tag, ".vec"},    32'(deadlock_vec),    32'(v));
    check({tag, ".count"},  32'(deadlock_count),  32'(c));
    $display("step %-14s flag=%0b report=%0b idx=%0d vec=%b count=%0d",
             tag, deadlock_flag, deadlock_report, deadlock_idx, deadlock_vec, deadlock_count);
  endtask

  logic [15:0] or_acc;

  initial begin
    reset_n   = 1'b0;
    mon_block = 4'b0000;
    clear     = 1'b0;
    tick(3);
    chk_all("in_reset", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);
    reset_n = 1'b1;
    tick(1);
    chk_all("reset_rel", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);

    // Long idle: nothing may ever appear on the outputs.
    or_acc = '0;
    for (int k = 0; k < 2000; k++) begin
      tick(1);
      or_acc = or_acc | {deadlock_flag, deadlock_report, deadlock_idx, deadlock_vec, deadlock_count};
    end
    check("idle_2000", 32'(or_acc), 32'd0);

    // Constant 0110: detection after the 8th sampling edge plus one.
    mon_block = 4'b0110;
    tick(8);
    chk_all("hold_pre", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);
    tick(1);
    chk_all("hold_det", 1'b1, 1'b1, 2'd1, 4'b0110, 8'd1);
    tick(1);
    chk_all("hold_post", 1'b1, 1'b0, 2'd1, 4'b0110, 8'd1);

    // DEADLOCK is absorbing while the monitors go quiet.
    mon_block = 4'b0000;
    tick(50);
    chk_all("absorb", 1'b1, 1'b0, 2'd1, 4'b0110, 8'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk_all("clear1", 1'b0, 1'b0, 2'd0, 4'h0, 8'd1);
    tick(3);

    // 7 samples of 0010, one zero sample, then 0010 held.
    mon_block = 4'b0010;
    tick(7);
    mon_block = 4'b0000;
    tick(1);
    mon_block = 4'b0010;
    tick(8);
    chk_all("gap_pre", 1'b0, 1'b0, 2'd0, 4'h0, 8'd1);
    tick(1);
    chk_all("gap_det", 1'b1, 1'b1, 2'd1, 4'b0010, 8'd2);

    clear     = 1'b1;
    mon_block = 4'b0000;
    tick(1);
    clear = 1'b0;
    tick(3);

    // 0010 for 4 samples, then 1010 from sample 5: window restarts at sample 5.
    mon_block = 4'b0010;
    tick(4);
    mon_block = 4'b1010;
    tick(8);
    chk_all("chg_pre", 1'b0, 1'b0, 2'd0, 4'h0, 8'd2);
    tick(1);
    chk_all("chg_det", 1'b1, 1'b1, 2'd1, 4'b1010, 8'd3);

    clear     = 1'b1;
    mon_block = 4'b0000;
    tick(1);
    clear = 1'b0;
    tick(3);

    // Clear lands on the edge that would have entered DEADLOCK.
    mon_block = 4'b0110;
    tick(8);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk_all("clr_race", 1'b0, 1'b0, 2'd0, 4'h0, 8'd3);
    tick(7);
    chk_all("redet_pre", 1'b0, 1'b0, 2'd0, 4'h0, 8'd3);
    tick(1);
    chk_all("redet", 1'b1, 1'b1, 2'd1, 4'b0110, 8'd4);

    // 256 more detect/clear rounds: count saturates at 255.
    for (int k = 0; k < 251; k++) begin
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(8);
    end
    chk_all("sat_255", 1'b1, 1'b1, 2'd1, 4'b0110, 8'd255);
    for (int k = 0; k < 5; k++) begin
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(8);
    end
    chk_all("sat_hold", 1'b1, 1'b1, 2'd1, 4'b0110, 8'd255);

    // Asynchronous reset in the middle of a SUSPECT window.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk_all("rst_suspect", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);
    tick(1);
    reset_n = 1'b1;
    tick(8);
    chk_all("rst_rel_pre", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);
    tick(1);
    chk_all("rst_rel_det", 1'b1, 1'b1, 2'd1, 4'b0110, 8'd1);

    // Asynchronous reset while in DEADLOCK.
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk_all("rst_deadlock", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk_all("rst_dl_rel", 1'b0, 1'b0, 2'd0, 4'h0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/generateproof_hls_deadlock_aggregator.md
# generateproof_hls_deadlock_aggregator

Persistence filter and reporter for the GenerateProof deadlock monitors. It collects the `block` outputs of up to NUM_MON per-instance monitors, including the INPUT_STREAM pipeline monitor. It declares a deadlock only when the same non-zero block pattern holds for THRESH consecutive samples. It then latches a sticky report (flag, culprit index, snapshot) for the host/debug path and holds it until software clears it.

## Interface
Parameters:
- NUM_MON, 4: number of monitor `block` inputs (1..32).
- THRESH, 1024: consecutive identical non-zero samples required to declare deadlock (2..65535).
- IDX_W, $clog2(NUM_MON) (min 1): culprit index width.

Ports:
- clock  in  1  single design clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mon_block  in  NUM_MON  block outputs of the monitors; bit i = monitor i.
- clear  in  1  synchronous report clear, one-cycle pulse or level.
- deadlock_flag  out  1  sticky deadlock indication.
- deadlock_report  out  1  one-cycle pulse on the deadlock entry edge.
- deadlock_idx  out  IDX_W  lowest set bit of the latched snapshot.
- deadlock_vec  out  NUM_MON  latched block pattern at detection.
- deadlock_count  out  8  saturating count of detections since reset.

## Operation
- Input register `mon_q <= mon_block` every cycle, including during clear.
- FSM states: IDLE, SUSPECT, DEADLOCK. Internal `snap` (NUM_MON) and 16-bit `cnt`.
- IDLE:
  - mon_q != 0 -> SUSPECT, snap <= mon_q, cnt <= 1.
  - Otherwise stay in IDLE with cnt = 0.
- SUSPECT, evaluated in this priority:
  - mon_q == 0 -> IDLE, cnt <= 0.
  - mon_q != snap -> snap <= mon_q, cnt <= 1. The pattern change restarts the window.
  - cnt == THRESH-1 -> DEADLOCK, cnt <= THRESH.
  - Otherwise cnt <= cnt+1.
- DEADLOCK entry, same edge as the transition:
  - deadlock_flag <= 1.
  - deadlock_vec <= snap.
  - deadlock_idx <= priority-encode(snap), lowest index wins.
  - deadlock_report high for exactly that one cycle.
  - deadlock_count <= count+1, saturating at 255.
- DEADLOCK is absorbing. mon_block changes, including dropping to 0, are ignored until clear.
- clear (synchronous, highest priority in every state):
  - Next state IDLE.
  - cnt, snap, deadlock_flag, deadlock_idx and deadlock_vec return to 0. deadlock_report is 0.
  - deadlock_count is not affected; only reset_n zeroes it.
- clear coincident with a would-be DEADLOCK entry: clear wins. No report pulse, no count increment.

## Timing
- Reset values: all outputs 0; state IDLE; mon_q, snap, cnt all 0.
- Reset mid-operation aborts any window or report immediately; there is no partial-report retention.
- Latency: if mon_block is a constant non-zero pattern sampled at edges k..k+THRESH-1, then deadlock_flag and deadlock_report assert after edge k+THRESH.
- A single-cycle zero, or any pattern change, inside the window delays detection. The full THRESH samples count from the first sample after the disturbance.
- After clear with mon_block still blocked: IDLE at edge c, SUSPECT at c+1, re-detection after edge c+THRESH.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package `generateproof_deadlock_pkg`:
  - state enum {IDLE, SUSPECT, DEADLOCK}.
  - CNT_W = 16 constant.
  - function `lowest_set_idx`.
- Sub-module `generateproof_deadlock_prienc`: parameterised NUM_MON -> IDX_W lowest-set-bit encoder with a valid output, purely combinational. It is instantiated once on snap; valid is used only for assertions.
- Remaining logic (input register, FSM, counters) is flat in the top module.

## Test plan
- Reset release, mon_block=0 for 2000 cycles -> all outputs remain 0, state IDLE.
- THRESH=8, NUM_MON=4, mon_block=4'b0110 held from edge 10 -> deadlock_report pulses once after edge 18; flag=1, idx=1, vec=0110, count=1.
- THRESH=8, mon_block=0010 for 7 samples, one sample 0000, then 0010 held -> no detection until 8 consecutive post-gap samples; a 0010 -> 1010 change at sample 5 likewise restarts, ending with vec=1010, idx=1.
- In DEADLOCK, drop mon_block to 0 for 50 cycles -> flag, idx and vec stay latched. Then pulse clear -> all report outputs 0 after that edge, count still 1.
- clear asserted on exactly the edge where cnt would reach THRESH -> no report pulse, count unchanged. With mon_block still 0110, re-detection occurs THRESH edges after clear, taking count to 2.
- 260 detect/clear cycles -> count saturates at 255. Assert reset_n low mid-SUSPECT and mid-DEADLOCK -> outputs 0 asynchronously.
